cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 16: tag field width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data field width.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 2: opcode field width.
REQ-004 SHALL have derived parameter LINE_WIDTH = OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH: cache command vector width.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have, for N = 0,1, ports reqN_valid in 1, reqN_op in OPCODE_WIDTH, reqN_tag in TAG_WIDTH, reqN_data in DATA_WIDTH  requester N command.
REQ-008 SHALL have, for N = 0,1, port reqN_ready  out  1  one-cycle accept pulse for requester N.
REQ-009 SHALL have ports flush_req in 1 (level flush request) and flush_done out 1 (one-cycle completion pulse).
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_id out 1, rsp_hit out 1, rsp_err out 1, rsp_data out DATA_WIDTH, rsp_evict_tag out TAG_WIDTH, rsp_evict_data out DATA_WIDTH  response channel.
REQ-011 SHALL have ports cache_vector out LINE_WIDTH and cache_enable out 1, driving the cache block's vector_in and enable.
REQ-012 SHALL have ports cache_data in DATA_WIDTH, cache_data_miss in DATA_WIDTH, cache_tag_miss in TAG_WIDTH, cache_hit in 1, fed from the cache block's data_out, data_out_miss, tag_out_miss, hit_miss_out.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, FLUSH_WAIT.
REQ-014 SHALL perform arbitration in IDLE only, with priority flush_req > round-robin between req0/req1.
REQ-015 Round-robin SHALL grant the requester not granted last when both are valid; last-grant pointer updates only on a requester grant.
REQ-016 Grant SHALL assert reqN_ready for exactly the IDLE cycle in which the command is captured; at most one ready per cycle.
REQ-017 cache_vector SHALL be registered as {op, tag, data}, opcode in MSBs, data in LSBs.
REQ-018 Granted READ/WRITE SHALL go IDLE->ISSUE, with cache_enable=1 for exactly the one ISSUE cycle.
REQ-019 ISSUE SHALL go to WAIT, and at the end of WAIT the cache outputs SHALL be captured into rsp_data, rsp_hit, rsp_evict_tag, rsp_evict_data, with rsp_id set to the grantee and rsp_err=0.
REQ-020 WAIT SHALL go to RESP, with rsp_valid held high and rsp_* held stable until a cycle with rsp_ready=1, then return to IDLE.
REQ-021 Issue-to-rsp_valid latency SHALL be exactly 2 cycles after the grant cycle, i.e. rsp_valid first high 3 cycles after reqN_ready.
REQ-022 A granted op that is not READ or WRITE SHALL bypass the cache and go IDLE->RESP directly, with rsp_err=1, rsp_hit=0 and zero data/evict fields.
REQ-023 Flush SHALL go IDLE->ISSUE with the FLASH opcode and zero tag/data, then ISSUE->FLUSH_WAIT, pulse flush_done one cycle and return to IDLE without asserting rsp_valid.
REQ-024 flush_req held high SHALL be serviced again on each IDLE visit.
REQ-025 cache_enable SHALL be 0 in every state except ISSUE.
REQ-026 Requests arriving while not in IDLE SHALL wait, with reqN_ready=0 and no internal queue.
REQ-027 rsp_ready SHALL be ignored outside RESP.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, cache_enable=0, cache_vector=0, reqN_ready=0, flush_done=0, rsp_valid=0 and all rsp_* fields=0.
REQ-029 Reset SHALL set the last-grant pointer to 1, so req0 wins the first tie.
REQ-030 Reset asserted mid-transaction SHALL abort it with no response; the cache contents are not restored.

Structure
REQ-031 Opcode encodings (FLASH, READ, WRITE, INVALID) and the HIT/MISS encodings SHALL come from the shared cache_defines include and are never redefined locally.
REQ-032 State encoding localparams SHALL be local to the module.
REQ-033 Arbitration SHALL be a sub-module rr_arb2 (2-way round-robin, pointer register, grant vector).
REQ-034 The testbench SHALL instantiate cache_arbiter together with the cache block.

Verification
REQ-035 Reset, req0 WRITE tag 5 data 0xAA: ready0 at t0, enable at t0+1, rsp_valid at t0+3 with rsp_id=0, rsp_err=0.
REQ-036 Then req1 READ tag 5: rsp_hit=1, rsp_data=0xAA, rsp_id=1.
REQ-037 req0 and req1 both valid for 4 transactions with rsp_ready=1: grants alternate 0,1,0,1.
REQ-038 flush_req and req0 both valid in IDLE: FLASH issued first, flush_done pulses, no rsp_valid for it; req0 granted next IDLE; a later READ tag 5 returns rsp_hit per cache block behaviour after flush.
REQ-039 rsp_ready held 0 for 5 cycles in RESP: rsp_* stable, no new grant; rsp_ready=1 returns to IDLE next cycle.
REQ-040 rst_n pulsed low during WAIT: all outputs zero immediately; first post-reset tie grants req0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared cache command definitions: opcode and hit/miss encodings used by the
// arbiter, its round-robin sub-block and anything that talks to the cache.
package cache_arbiter_pkg;

  // Cache opcode encodings (zero-extended/truncated to OPCODE_WIDTH at use).
  localparam int OP_FLASH   = 0;
  localparam int OP_READ    = 1;
  localparam int OP_WRITE   = 2;
  localparam int OP_INVALID = 3;

  // Encoding of the cache block's hit_miss_out signal.
  localparam logic HIT  = 1'b1;
  localparam logic MISS = 1'b0;

  // Two-way round-robin pick: a lone requester always wins; on a tie the
  // requester that was not granted last wins. Returns a one-hot grant vector.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] pick;
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants only while en is high; the last-grant
// pointer moves only when a grant is actually issued.
module rr_arb2
  import cache_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; 1 after reset so req0 wins the first tie.
  logic last;

  // Combinational one-hot grant from the request pair and the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    grant = 2'b00;
    if (en) grant = rr_pick(req, last);
  end

  // Pointer register: remembers which requester was served last.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n)       last <= 1'b1;
    else if (|grant)  last <= grant[1];
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates two requesters and a flush request onto a single cache command
// port, waits for the cache result and returns it on a ready/valid response
// channel. One transaction is in flight at a time; nothing is queued.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter  int TAG_WIDTH    = 16,
  parameter  int DATA_WIDTH   = 32,
  parameter  int OPCODE_WIDTH = 2,
  localparam int LINE_WIDTH   = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req0_valid,
  input  logic [OPCODE_WIDTH-1:0] req0_op,
  input  logic [TAG_WIDTH-1:0]    req0_tag,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ready,

  input  logic                    req1_valid,
  input  logic [OPCODE_WIDTH-1:0] req1_op,
  input  logic [TAG_WIDTH-1:0]    req1_tag,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    req1_ready,

  input  logic                    flush_req,
  output logic                    flush_done,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic                    rsp_hit,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_evict_tag,
  output logic [DATA_WIDTH-1:0]   rsp_evict_data,

  output logic [LINE_WIDTH-1:0]   cache_vector,
  output logic                    cache_enable,

  input  logic [DATA_WIDTH-1:0]   cache_data,
  input  logic [DATA_WIDTH-1:0]   cache_data_miss,
  input  logic [TAG_WIDTH-1:0]    cache_tag_miss,
  input  logic                    cache_hit
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    FLUSH_WAIT
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic                    arb_en;
  logic [1:0]              grant;
  logic                    grant_any;
  logic                    grant_id;
  logic                    flush_go;
  logic [OPCODE_WIDTH-1:0] sel_op;
  logic [TAG_WIDTH-1:0]    sel_tag;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_is_cache_op;
  logic                    issue_is_flush;
  logic                    txn_id;

  // Requesters compete only in IDLE and only when no flush is pending. The
  // reset term keeps the ready pulses low while rst_n is asserted.
  assign arb_en    = rst_n && (state == IDLE) && !flush_req;
  assign flush_go  = (state == IDLE) && flush_req;
  assign grant_any = |grant;
  assign grant_id  = grant[1];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en),
    .grant (grant)
  );

  // Mux the winning requester's command fields.
  always_comb begin
    sel_op   = req0_op;
    sel_tag  = req0_tag;
    sel_data = req0_data;
    if (grant_id) begin
      sel_op   = req1_op;
      sel_tag  = req1_tag;
      sel_data = req1_data;
    end
  end

  assign sel_is_cache_op = (sel_op == OPCODE_WIDTH'(OP_READ)) ||
                           (sel_op == OPCODE_WIDTH'(OP_WRITE));

  // A requester FLASH op bypasses the cache, so FLASH in the issued vector
  // can only come from the flush path.
  assign issue_is_flush = (cache_vector[LINE_WIDTH-1 -: OPCODE_WIDTH] == OPCODE_WIDTH'(OP_FLASH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next   = state;
    cache_enable = 1'b0;
    rsp_valid    = 1'b0;
    flush_done   = 1'b0;
    req0_ready   = grant[0];
    req1_ready   = grant[1];
    unique case (state)
      IDLE: begin
        if (flush_go)       state_next = ISSUE;
        else if (grant_any) state_next = sel_is_cache_op ? ISSUE : RESP;
      end
      ISSUE: begin
        cache_enable = 1'b1;
        state_next   = issue_is_flush ? FLUSH_WAIT : WAIT;
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      FLUSH_WAIT: begin
        flush_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture on grant/flush and response capture at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vector   <= '0;
      txn_id         <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_data       <= '0;
      rsp_evict_tag  <= '0;
      rsp_evict_data <= '0;
    end else begin
      if (flush_go) begin
        cache_vector <= {OPCODE_WIDTH'(OP_FLASH), {TAG_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
      end else if (grant_any) begin
        txn_id <= grant_id;
        if (sel_is_cache_op) begin
          cache_vector <= {sel_op, sel_tag, sel_data};
        end else begin
          // Unsupported op: answer immediately with an error, cache untouched.
          rsp_id         <= grant_id;
          rsp_hit        <= 1'b0;
          rsp_err        <= 1'b1;
          rsp_data       <= '0;
          rsp_evict_tag  <= '0;
          rsp_evict_data <= '0;
        end
      end
      if (state == WAIT) begin
        rsp_id         <= txn_id;
        rsp_hit        <= (cache_hit == HIT);
        rsp_err        <= 1'b0;
        rsp_data       <= cache_data;
        rsp_evict_tag  <= cache_tag_miss;
        rsp_evict_data <= cache_data_miss;
      end
    end
  end

endmodule
